// File: rtl/demux_reg_array.sv
// Registered 1-to-CH demultiplexer: each output channel owns a one-entry
// holding register, filled from the single upstream port by sel.
module demux_reg_array #(
  parameter int SIZE      = 16,
  parameter int SEL_WIDTH = 2,
  localparam int CH       = 2**SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic [SIZE-1:0]      in_data,
  output logic [CH*SIZE-1:0]   out_data,
  output logic [CH-1:0]        out_valid,
  input  logic [CH-1:0]        out_ready,
  output logic [15:0]          xfer_count
);

  // Handshake: a word moves on any cycle where valid & ready are both high at
  // the rising edge; the sender holds word and valid stable until that cycle,
  // and ready never depends on anything except the target slot's state.
  logic          accept;
  logic [CH-1:0] load;
  logic [CH-1:0] pop;

  // The addressed slot can take a word if it is empty or being drained now.
  assign in_ready = ~out_valid[sel] | out_ready[sel];
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_comb begin
    load = '0;
    if (accept) load[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= '0;
      xfer_count <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (load[k]) out_data[k*SIZE +: SIZE] <= in_data;
      end
      // Load wins over pop, so a drain-and-refill keeps the flag set.
      out_valid <= (out_valid & ~pop) | load;
      if (accept) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_demux_reg_array.sv
// Bench for demux_reg_array: vector table plus directed streaming, reset and
// counter-wrap sequences, with a per-word scoreboard on every channel pop.
module tb_demux_reg_array;

  localparam int SIZE      = 16;
  localparam int SEL_WIDTH = 2;
  localparam int CH        = 4;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_WIDTH-1:0] sel;
  logic [SIZE-1:0]      in_data;
  logic [CH*SIZE-1:0]   out_data;
  logic [CH-1:0]        out_valid;
  logic [CH-1:0]        out_ready;
  logic [15:0]          xfer_count;

  always #5 clk = ~clk;

  demux_reg_array #(.SIZE(SIZE), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [SIZE-1:0]           m_data [CH];
  logic [CH-1:0]             m_valid;
  logic [15:0]               m_count;
  logic [SEL_WIDTH+SIZE-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called with inputs applied, just before the rising edge.
  task automatic model_step();
    logic acc;
    int   idx;
    if (reset) begin
      for (int k = 0; k < CH; k++) m_data[k] = '0;
      m_valid = '0;
      m_count = '0;
      exp_q.delete();
      return;
    end
    acc = in_valid & (~m_valid[sel] | out_ready[sel]);
    for (int k = 0; k < CH; k++) begin
      if (m_valid[k] && out_ready[k]) begin
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (idx < 0 && exp_q[j][SIZE +: SEL_WIDTH] == SEL_WIDTH'(k)) idx = j;
        end
        if (idx < 0) begin
          chk("sb_empty_on_pop", 64'(k), 64'hffff);
        end else begin
          chk("sb_pop_data", 64'(out_data[k*SIZE +: SIZE]), 64'(exp_q[idx][SIZE-1:0]));
          exp_q.delete(idx);
        end
        m_valid[k] = 1'b0;
      end
    end
    if (acc) begin
      m_data[sel]  = in_data;
      m_valid[sel] = 1'b1;
      m_count      = m_count + 16'd1;
      exp_q.push_back({sel, in_data});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [SEL_WIDTH-1:0] s,
                       input logic [SIZE-1:0] d, input logic [CH-1:0] ordy);
    in_valid  = iv;
    sel       = s;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    for (int k = 0; k < CH; k++)
      chk({tag, "_data"}, 64'(out_data[k*SIZE +: SIZE]), 64'(m_data[k]));
    chk({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, "_count"}, 64'(xfer_count), 64'(m_count));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                 iv;
    logic [SEL_WIDTH-1:0] sel;
    logic [SIZE-1:0]      data;
    logic [CH-1:0]        ordy;
    logic                 exp_rdy;
    logic [CH-1:0]        exp_valid;
    logic [15:0]          exp_count;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // route, backpressure, pass-through, independence, idle pops
    vecs[0]  = '{1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0100, 16'd1};
    vecs[1]  = '{1'b1, 2'd1, 16'h1111, 4'b0000, 1'b1, 4'b0110, 16'd2};
    vecs[2]  = '{1'b1, 2'd1, 16'h2222, 4'b0000, 1'b0, 4'b0110, 16'd2};
    vecs[3]  = '{1'b1, 2'd1, 16'h2222, 4'b0010, 1'b1, 4'b0110, 16'd3};
    vecs[4]  = '{1'b1, 2'd0, 16'hA0A0, 4'b0000, 1'b1, 4'b0111, 16'd4};
    vecs[5]  = '{1'b1, 2'd3, 16'h3333, 4'b0000, 1'b1, 4'b1111, 16'd5};
    vecs[6]  = '{1'b1, 2'd0, 16'hDEAD, 4'b0000, 1'b0, 4'b1111, 16'd5};
    vecs[7]  = '{1'b0, 2'd0, 16'hFFFF, 4'b1000, 1'b0, 4'b0111, 16'd5};
    vecs[8]  = '{1'b1, 2'd3, 16'h4444, 4'b0101, 1'b1, 4'b1010, 16'd6};
    vecs[9]  = '{1'b0, 2'd2, 16'h5555, 4'b0101, 1'b1, 4'b1010, 16'd6};
    vecs[10] = '{1'b0, 2'd1, 16'h6666, 4'b1010, 1'b1, 4'b0000, 16'd6};

    // reset state
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_count", 64'(xfer_count), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_count", i), 64'(xfer_count), 64'(vecs[i].exp_count));
      chk_model($sformatf("vec%0d", i));
      if (i == 0) chk("route_ch2_data", 64'(out_data[47:32]), 64'hBEEF);
      if (i == 2) chk("bp_ch1_held", 64'(out_data[31:16]), 64'h1111);
      if (i == 6) chk("indep_ch0_held", 64'(out_data[15:0]), 64'hA0A0);
    end

    // streaming through channel 0
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'd0, 16'(i), 4'b0001);
      chk("stream_in_ready", 64'(in_ready), 64'h1);
      tick();
      chk("stream_data", 64'(out_data[15:0]), 64'(i));
      chk("stream_valid0", 64'(out_valid[0]), 64'h1);
    end
    chk("stream_count", 64'(xfer_count), 64'd8);
    drive(1'b0, 2'd0, '0, 4'b0001);
    tick();
    chk_model("stream_drain");

    // reset mid-operation with all channels full
    for (int k = 0; k < CH; k++) begin
      drive(1'b1, SEL_WIDTH'(k), 16'h7000 + 16'(k), 4'b0000);
      tick();
    end
    chk("full_valid", 64'(out_valid), 64'hF);
    reset = 1'b1;
    drive(1'b1, 2'd2, 16'h9999, 4'b1111);
    tick();
    reset = 1'b0;
    drive(1'b0, 2'd2, '0, 4'b0000);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_data", 64'(out_data), 64'h0);
    chk("midrst_count", 64'(xfer_count), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h1);

    // counter wrap
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 2'd0, 16'(i), 4'b0001);
      tick();
    end
    chk("wrap_pre", 64'(xfer_count), 64'hFFFF);
    drive(1'b1, 2'd0, 16'h1234, 4'b0001);
    tick();
    chk("wrap_post", 64'(xfer_count), 64'h0);
    chk_model("wrap_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_reg_array.md
DEMUX_REG_ARRAY -- requirements
Module: demux_reg_array

Interface
REQ-001 SHALL have parameter SIZE, default 16, the data word width in bits.
REQ-002 SHALL have parameter SEL_WIDTH, default 2, the select width; channel count CH = 2**SEL_WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream word is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the upstream word this cycle.
REQ-007 SHALL have port sel, input, SEL_WIDTH, the destination channel index, qualified by in_valid.
REQ-008 SHALL have port in_data, input, SIZE, the upstream word.
REQ-009 SHALL have port out_data, output, CH*SIZE, channel k data in bits [k*SIZE +: SIZE].
REQ-010 SHALL have port out_valid, output, CH, where bit k means channel k holds an unconsumed word.
REQ-011 SHALL have port out_ready, input, CH, where bit k means channel k's consumer takes its word this cycle.
REQ-012 SHALL have port xfer_count, output, 16, the count of accepted upstream words.

Function
REQ-013 SHALL give each channel a one-entry holding register (data plus valid flag), i.e. a registered 1-to-CH demultiplexer.
REQ-014 SHALL compute in_ready combinationally as ~out_valid[sel] | out_ready[sel], with no other term.
REQ-015 SHALL define the upstream accept condition as in_valid & in_ready, evaluated in the same cycle.
REQ-016 SHALL, on accept, load in_data into channel sel's data register and set out_valid[sel] at the next edge, for a latency of 1 cycle.
REQ-017 SHALL define a channel k pop as out_valid[k] & out_ready[k], which clears out_valid[k] at the next edge unless the same channel is refilled.
REQ-018 SHALL treat a simultaneous pop and accept on the same channel as pass-through: the new word is loaded and out_valid[k] stays 1, with no bubble.
REQ-019 SHALL allow pops on any subset of channels in the same cycle as an accept to a different channel, each independently.
REQ-020 SHALL hold a full channel stable: out_data[k] SHALL not change while out_valid[k]=1 and no pop occurs.
REQ-021 SHALL never write or disturb a channel other than sel.
REQ-022 SHALL ignore out_ready[k] while out_valid[k]=0.
REQ-023 SHALL ignore in_data and sel while in_valid=0.
REQ-024 SHALL never drop an upstream word: when in_ready=0 the word is not accepted and upstream must hold it.
REQ-025 SHALL increment xfer_count by 1 on each accept, wrapping from 16'hFFFF to 16'h0000 with no flag.
REQ-026 SHALL not let the out_data value of an empty channel affect any behaviour; it holds the last loaded value.

Reset
REQ-027 SHALL, while reset=1 at a clk edge, clear all out_valid bits, all out_data registers and xfer_count to 0.
REQ-028 SHALL suppress accepts and count increments on a reset edge, even if in_valid=1.
REQ-029 SHALL let in_ready follow its combinational definition during reset; after reset out_valid=0, so in_ready=1 on the first cycle.
REQ-030 SHALL, on reset mid-operation, discard all held words and suppress all pending pops.

Verification
REQ-031 SHALL cover basic route: after reset, sel=2, in_data=16'hBEEF, in_valid=1 for 1 cycle -> next cycle out_valid=4'b0100, out_data[47:32]=16'hBEEF, xfer_count=1.
REQ-032 SHALL cover backpressure: channel 1 full and out_ready[1]=0, with sel=1, in_valid=1 -> in_ready=0, channel 1 unchanged, xfer_count unchanged; then out_ready[1]=1 -> in_ready=1, the new word loads and out_valid[1] stays 1.
REQ-033 SHALL cover channel independence: channel 0 full and stalled, with words sent to sel=3 -> in_ready=1, channel 3 loads, channel 0 data and valid are untouched.
REQ-034 SHALL cover streaming: sel=0 with out_ready[0]=1 held and 8 back-to-back words 1..8 -> channel 0 shows 1..8 on consecutive cycles, in_ready stays 1, xfer_count=8.
REQ-035 SHALL cover wrap: drive xfer_count to 16'hFFFF, then 1 accept -> xfer_count=16'h0000.
REQ-036 SHALL cover reset mid-operation: all 4 channels full, assert reset for 1 cycle with in_valid=1 -> out_valid=4'b0000, all out_data=0, xfer_count=0, in_ready=1.
